counter_dp: RTL
===============

# counter_dp

Parametrised successor to the fixed 16-bit ±1 counter datapath. It holds a WIDTH-bit count register updated by a programmable step, up or down, within the range [0, limit]. At the range ends it either saturates or wraps, selectable at run time. It carries its own RUN/DONE controller, so a parent FSM only issues start/stop, and it reports zero/limit status, a sticky overflow flag, a wrap pulse and a done pulse.

## Interface
- WIDTH, 16: count register, d_in and limit width
- STEP_W, 8: step input width; must be ≤ WIDTH
- RESET_VAL, 0: count value after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock domain only
- c_clr  in  1  synchronous clear of count and ovf; aborts RUN
- c_ld  in  1  synchronous load of min(d_in, limit); aborts RUN
- d_in  in  WIDTH  load value
- op  in  1  0 = count up, 1 = count down
- step  in  STEP_W  increment magnitude, zero-extended
- limit  in  WIDTH  upper bound of the range
- sat  in  1  1 = saturate, 0 = wrap modulo (limit+1)
- en  in  1  count qualifier while in RUN
- start  in  1  IDLE→RUN request
- stop  in  1  RUN→IDLE request
- c_out  out  WIDTH  current count
- z  out  1  c_out == 0 (combinational)
- m  out  1  c_out == limit (combinational)
- ovf  out  1  sticky: a range boundary was crossed
- wrap  out  1  one-cycle registered pulse after a wrap update
- busy  out  1  state == RUN
- done  out  1  state == DONE (one cycle)

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→IDLE on stop, c_clr or c_ld.
  - RUN→DONE when sat=1 and the count update lands on the terminal value: limit if op=0, 0 if op=1.
  - DONE→IDLE unconditionally after one cycle.
  - With sat=0, RUN never goes to DONE.
- Per-edge priority: reset > c_clr > c_ld > stop > count.
  - start is ignored outside IDLE.
  - start is ignored when c_clr or c_ld is asserted in the same cycle.
- Counting happens only in RUN with en=1 and stop=0. Otherwise the count holds.
- Arithmetic is done at WIDTH+1 bits; s is step zero-extended.
- Up (op=0), sum = c + s:
  - sum ≤ limit → c = sum.
  - sum > limit, sat=1 → c = limit, ovf=1.
  - sum > limit, sat=0 → c = sum − limit − 1, ovf=1, wrap pulse.
- Down (op=1):
  - c ≥ s → c = c − s.
  - c < s, sat=1 → c = 0, ovf=1.
  - c < s, sat=0 → c = c + limit + 1 − s, ovf=1, wrap pulse.
- Step larger than the range: if s > limit and sat=0, the update is performed as sat=1 (clamp) with ovf=1. A single fold is always in range.
- step = 0 counts as a no-op update. In sat mode, if the count already equals the terminal value, RUN→DONE is still taken.
- Loads above limit clamp to limit. ovf is not set by a load.
- ovf is cleared only by reset, c_clr, or an accepted start.
- A limit change while in RUN takes effect on the next update. If c > new limit, the next up-update is handled as the sum > limit case.

## Timing
- Reset values: c_out = RESET_VAL, state = IDLE, ovf = 0, wrap = 0, done = 0, busy = 0. z and m follow from c_out.
- start sampled at edge k → busy=1 after edge k. The first count is applied at edge k+1 if en=1.
- Count latency is one edge. c_out, ovf and wrap are registered; z and m are combinational from c_out.
- The terminal update at edge n gives done=1 after edge n, for exactly one cycle. busy drops after edge n.
- stop, c_clr or c_ld at edge n gives busy=0 after edge n, with no done.
- Reset mid-RUN asynchronously forces every output to its reset value.

## Test plan
- Up, saturate: WIDTH=8, limit=10, step=3, sat=1, op=0. Load 0, start, hold en=1.
  - c_out = 3, 6, 9, 10.
  - ovf=1 on the 9→10 update.
  - done=1 for one cycle after 10.
  - Then busy=0 and m=1.
- Wrap up: limit=9, step=4, sat=0. Load 7, start, en=1.
  - c_out = 1, 5, 9, 3.
  - wrap pulses after the 7→1 and 9→3 updates.
  - busy stays 1; done never asserts.
- Down, saturate and wrap: limit=255, step=5, op=1.
  - sat=1 from load 7: c_out = 2, 0, z=1, done.
  - sat=0 from load 2: c_out = 253, wrap=1.
- Priority: in RUN, assert c_ld (d_in=200, limit=100) and stop together.
  - c_out = 100, busy=0, done=0.
  - A start in the same cycle as c_clr is ignored.
- Edge cases:
  - step=20 with limit=9, sat=0: update clamps to 9 with ovf=1.
  - en=0 in RUN holds the count.
  - A stray start while in RUN is ignored.
- Async reset: assert reset between edges mid-RUN.
  - c_out = RESET_VAL and busy, ovf, wrap, done all 0, immediately and without waiting for a clock edge.

Source files
------------

// File: rtl/counter_dp.sv
// rtl/counter_dp.sv - parametrised up/down step counter with saturate/wrap range and RUN/DONE control
module counter_dp #(
    parameter int               WIDTH     = 16,
    parameter int               STEP_W    = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_clr,
    input  logic              c_ld,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              op,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    output logic [WIDTH-1:0]  c_out,
    output logic              z,
    output logic              m,
    output logic              ovf,
    output logic              wrap,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] s_w;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] term;
    logic             clamp;
    logic             bound;
    logic             wrapped;

    assign s_w = WIDTH'(step);

    // Fold results are computed modulo 2^WIDTH; the true value always fits in WIDTH bits.
    always_comb begin
        nxt     = cnt;
        bound   = 1'b0;
        wrapped = 1'b0;
        clamp   = sat | (s_w > limit);
        sum     = {1'b0, cnt} + {1'b0, s_w};
        if (!op) begin
            if (sum <= {1'b0, limit}) begin
                nxt = sum[WIDTH-1:0];
            end else if (clamp) begin
                nxt   = limit;
                bound = 1'b1;
            end else begin
                nxt     = cnt + s_w - limit - ONE;
                bound   = 1'b1;
                wrapped = 1'b1;
            end
        end else begin
            if (cnt >= s_w) begin
                nxt = cnt - s_w;
            end else if (clamp) begin
                nxt   = '0;
                bound = 1'b1;
            end else begin
                nxt     = cnt + limit + ONE - s_w;
                bound   = 1'b1;
                wrapped = 1'b1;
            end
        end
        term = op ? '0 : limit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= RESET_VAL;
            ovf   <= 1'b0;
            wrap  <= 1'b0;
            state <= S_IDLE;
        end else begin
            wrap <= 1'b0;
            if (c_clr) begin
                cnt   <= '0;
                ovf   <= 1'b0;
                state <= S_IDLE;
            end else if (c_ld) begin
                cnt   <= (d_in > limit) ? limit : d_in;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_RUN;
                            ovf   <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            state <= S_IDLE;
                        end else if (en) begin
                            cnt  <= nxt;
                            wrap <= wrapped;
                            if (bound) begin
                                ovf <= 1'b1;
                            end
                            // Only a saturating range has a terminal value.
                            if (sat && (nxt == term)) begin
                                state <= S_DONE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign c_out = cnt;
    assign z     = (cnt == '0);
    assign m     = (cnt == limit);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

endmodule
